// File: rtl/dmi_arbiter_if.sv
// DMI bundle shared by the debug masters, the arbiter and the debug module.
// The arbiter uses the slave modport; masters and the debug module sit on the master side.
interface dmi_arbiter_if #(
  parameter int NumReq = 2
);
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  dmi_req_t  [NumReq-1:0] req_i;
  logic      [NumReq-1:0] req_valid_i;
  logic      [NumReq-1:0] req_ready_o;
  logic      [NumReq-1:0] lock_i;
  dmi_resp_t [NumReq-1:0] resp_o;
  logic      [NumReq-1:0] resp_valid_o;
  logic      [NumReq-1:0] resp_ready_i;

  dmi_req_t  dmi_req_o;
  logic      dmi_req_valid_o;
  logic      dmi_req_ready_i;
  dmi_resp_t dmi_resp_i;
  logic      dmi_resp_valid_i;
  logic      dmi_resp_ready_o;

  modport slave (
    input  req_i, req_valid_i, lock_i, resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o,
    output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

  modport master (
    output req_i, req_valid_i, lock_i, resp_ready_i,
    output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o,
    input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one debug-module DMI port among NumReq masters,
// one transaction outstanding at a time, with an optional per-master lock.
module dmi_arbiter #(
  parameter int NumReq = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  dmi_arbiter_if.slave              bus,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_o
);
  localparam int GrantW = $clog2(NumReq);
  localparam int CandW  = GrantW + 1;

  typedef enum logic [1:0] {
    Idle,
    Req,
    Resp
  } state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q;
  logic [GrantW-1:0]   rr_q;
  logic                locked_q;

  logic                pick_valid;
  logic [GrantW-1:0]   pick_idx;
  logic [CandW-1:0]    cand;
  logic                req_hs;
  logic                resp_hs;

  // Walk from the highest offset down so the lowest index at or after rr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = grant_q;
    cand       = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + CandW'(k);
      if (cand >= CandW'(NumReq)) begin
        cand = cand - CandW'(NumReq);
      end
      if (!locked_q && bus.req_valid_i[cand[GrantW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[GrantW-1:0];
      end
    end
    if (locked_q) begin
      pick_valid = bus.req_valid_i[grant_q];
    end
  end

  assign req_hs  = (state_q == Req) && bus.req_valid_i[grant_q] && bus.dmi_req_ready_i;
  assign resp_hs = (state_q == Resp) && bus.dmi_resp_valid_i && bus.resp_ready_i[grant_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (pick_valid) state_d = Req;
      Req:     if (req_hs)     state_d = Resp;
      Resp:    if (resp_hs)    state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // The pointer moves past the completing master even under lock, so fairness resumes on unlock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q  <= '0;
      rr_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      if ((state_q == Idle) && pick_valid) begin
        grant_q <= pick_idx;
      end
      if (resp_hs) begin
        locked_q <= bus.lock_i[grant_q];
        rr_q     <= (grant_q == GrantW'(NumReq - 1)) ? '0 : grant_q + GrantW'(1);
      end
    end
  end

  always_comb begin
    bus.dmi_req_o        = '0;
    bus.dmi_req_valid_o  = 1'b0;
    bus.req_ready_o      = '0;
    bus.resp_o           = '0;
    bus.resp_valid_o     = '0;
    bus.dmi_resp_ready_o = 1'b0;
    case (state_q)
      Req: begin
        bus.dmi_req_o            = bus.req_i[grant_q];
        bus.dmi_req_valid_o      = bus.req_valid_i[grant_q];
        bus.req_ready_o[grant_q] = bus.dmi_req_ready_i;
      end
      Resp: begin
        for (int i = 0; i < NumReq; i++) begin
          bus.resp_o[i] = bus.dmi_resp_i;
        end
        bus.resp_valid_o[grant_q] = bus.dmi_resp_valid_i;
        bus.dmi_resp_ready_o      = bus.resp_ready_i[grant_q];
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != Idle);
  assign grant_o = grant_q;
endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed vector table, hand-written reset/lock sequences,
// then random traffic predicted by a transaction-level round-robin model.
module tb_dmi_arbiter;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [0:0] grant;

  int total = 0;
  int bad   = 0;

  dmi_arbiter_if #(.NumReq(N)) ifc ();

  dmi_arbiter #(.NumReq(N)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (ifc.slave),
    .busy_o (busy),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] lock;
    logic [6:0]   addr0;
    logic [6:0]   addr1;
    logic [1:0]   op;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    int           req_dly;
    int           rsp_dly;
    int           rdy_dly;
    int           exp_win;
  } vec_t;

  vec_t         vecs [12];
  logic [40:0]  req_word [N];
  logic [N-1:0] pending;
  logic [N-1:0] lock_bits;
  int           m_rr;
  int           m_grant;
  logic         m_locked;
  int           win;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int m, input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
    req_word[m]        = {addr, op, data};
    ifc.req_i[m]       = req_word[m];
    ifc.req_valid_i[m] = 1'b1;
    pending[m]         = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    ifc.req_valid_i = '0;
    pending         = '0;
    ifc.lock_i      = v.lock;
    if (v.valid[0]) drive_req(0, v.addr0, v.op, 32'hC0DE_0000 | 32'(v.addr0));
    if (v.valid[1]) drive_req(1, v.addr1, v.op, 32'hC0DE_0000 | 32'(v.addr1));
  endtask

  // Entered just after a falling edge while the arbiter is Idle and requests are driven.
  task automatic serve_txn(input int exp_win, input int req_dly, input int rsp_dly, input int rdy_dly,
                           input logic [31:0] rdata, input logic [1:0] rresp);
    @(negedge clk); #1;
    checkOutput("grant", 64'(grant), 64'(exp_win));
    checkOutput("dmi_req_valid", 64'(ifc.dmi_req_valid_o), 64'(1));
    checkOutput("dmi_req", 64'(ifc.dmi_req_o), 64'(req_word[exp_win]));
    repeat (req_dly) begin
      checkOutput("req_ready_stall", 64'(ifc.req_ready_o), 64'(0));
      @(negedge clk); #1;
      checkOutput("dmi_req_stable", 64'(ifc.dmi_req_o), 64'(req_word[exp_win]));
    end
    ifc.dmi_req_ready_i = 1'b1; #1;
    checkOutput("req_ready", 64'(ifc.req_ready_o), 64'(1) << exp_win);
    @(negedge clk);
    ifc.dmi_req_ready_i      = 1'b0;
    ifc.req_valid_i[exp_win] = 1'b0;
    pending[exp_win]         = 1'b0;
    #1;
    checkOutput("busy_resp", 64'(busy), 64'(1));
    checkOutput("dmi_req_valid_resp", 64'(ifc.dmi_req_valid_o), 64'(0));
    repeat (rsp_dly) begin
      checkOutput("resp_valid_wait", 64'(ifc.resp_valid_o), 64'(0));
      @(negedge clk); #1;
    end
    ifc.dmi_resp_i       = {rdata, rresp};
    ifc.dmi_resp_valid_i = 1'b1; #1;
    checkOutput("resp_valid", 64'(ifc.resp_valid_o), 64'(1) << exp_win);
    repeat (rdy_dly) begin
      checkOutput("dmi_resp_ready_stall", 64'(ifc.dmi_resp_ready_o), 64'(0));
      @(negedge clk); #1;
      checkOutput("busy_resp_stall", 64'(busy), 64'(1));
    end
    ifc.resp_ready_i[exp_win] = 1'b1; #1;
    checkOutput("dmi_resp_ready", 64'(ifc.dmi_resp_ready_o), 64'(1));
    checkOutput("resp_data", 64'(ifc.resp_o[exp_win]), 64'({rdata, rresp}));
    checkOutput("resp_bcast", 64'(ifc.resp_o[(exp_win + 1) % N]), 64'({rdata, rresp}));
    @(negedge clk);
    ifc.dmi_resp_valid_i = 1'b0;
    ifc.resp_ready_i     = '0;
    ifc.dmi_resp_i       = '0;
    #1;
    checkOutput("busy_idle", 64'(busy), 64'(0));
    checkOutput("idle_quiet", 64'({ifc.dmi_req_valid_o, ifc.req_ready_o, ifc.resp_valid_o, ifc.dmi_resp_ready_o}), 64'(0));
  endtask

  // Whole-transaction view: a held lock pins the grant, otherwise first pending master from the pointer.
  function automatic int predict_winner();
    if (m_locked) return m_grant;
    for (int k = 0; k < N; k++) begin
      if (pending[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'b01, 2'b00, 7'h11, 7'h00, 2'd1, 32'h0000_0A5A, 2'd0, 0, 1, 0, 0};
    vecs[1]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd1, 32'h0000_0001, 2'd0, 0, 0, 0, 1};
    vecs[2]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd1, 32'h0000_0002, 2'd0, 0, 0, 0, 0};
    vecs[3]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd1, 32'h0000_0003, 2'd0, 0, 0, 0, 1};
    vecs[4]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd1, 32'h0000_0004, 2'd0, 0, 0, 0, 0};
    vecs[5]  = '{2'b11, 2'b10, 7'h04, 7'h10, 2'd2, 32'h0000_0005, 2'd0, 0, 0, 0, 1};
    vecs[6]  = '{2'b11, 2'b10, 7'h04, 7'h10, 2'd2, 32'h0000_0006, 2'd0, 1, 0, 0, 1};
    vecs[7]  = '{2'b11, 2'b10, 7'h04, 7'h10, 2'd2, 32'h0000_0007, 2'd0, 0, 1, 0, 1};
    vecs[8]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd2, 32'h0000_0008, 2'd0, 0, 0, 1, 1};
    vecs[9]  = '{2'b11, 2'b00, 7'h04, 7'h10, 2'd1, 32'h0000_0009, 2'd0, 0, 0, 0, 0};
    vecs[10] = '{2'b10, 2'b00, 7'h00, 7'h2A, 2'd1, 32'h1357_9BDF, 2'd0, 5, 0, 4, 1};
    vecs[11] = '{2'b01, 2'b00, 7'h33, 7'h00, 2'd1, 32'hDEAD_BEEF, 2'd2, 0, 0, 0, 0};

    rst                  = 1'b1;
    ifc.req_i            = '0;
    ifc.req_valid_i      = '0;
    ifc.lock_i           = '0;
    ifc.resp_ready_i     = '0;
    ifc.dmi_req_ready_i  = 1'b0;
    ifc.dmi_resp_i       = '0;
    ifc.dmi_resp_valid_i = 1'b0;
    pending              = '0;
    for (int m = 0; m < N; m++) req_word[m] = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_grant", 64'(grant), 64'(0));
    checkOutput("reset_dmi_req", 64'(ifc.dmi_req_o), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput("idle_no_req_valid", 64'(ifc.dmi_req_valid_o), 64'(0));
      serve_txn(vecs[i].exp_win, vecs[i].req_dly, vecs[i].rsp_dly, vecs[i].rdy_dly, vecs[i].rdata, vecs[i].rresp);
    end

    // Reset while master 1 is waiting in the response phase.
    ifc.lock_i = '0;
    drive_req(1, 7'h21, 2'd1, 32'h0);
    @(negedge clk); #1;
    checkOutput("rst_seq_req_valid", 64'(ifc.dmi_req_valid_o), 64'(1));
    ifc.dmi_req_ready_i = 1'b1;
    @(negedge clk);
    ifc.dmi_req_ready_i  = 1'b0;
    ifc.req_valid_i[1]   = 1'b0;
    pending[1]           = 1'b0;
    ifc.dmi_resp_i       = {32'h1234_5678, 2'd0};
    ifc.dmi_resp_valid_i = 1'b1;
    #1;
    checkOutput("rst_seq_in_resp", 64'(ifc.resp_valid_o), 64'(2'b10));
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("rst_mid_busy", 64'(busy), 64'(0));
    checkOutput("rst_mid_grant", 64'(grant), 64'(0));
    checkOutput("rst_mid_quiet", 64'({ifc.dmi_req_valid_o, ifc.req_ready_o, ifc.resp_valid_o, ifc.dmi_resp_ready_o}), 64'(0));
    checkOutput("rst_mid_dmi_req", 64'(ifc.dmi_req_o), 64'(0));
    rst                  = 1'b0;
    ifc.dmi_resp_valid_i = 1'b0;
    ifc.dmi_resp_i       = '0;

    // Master 1 is served after reset and takes the lock.
    ifc.lock_i = 2'b10;
    drive_req(1, 7'h22, 2'd2, 32'hCAFE_F00D);
    serve_txn(1, 0, 0, 0, 32'h0000_0042, 2'd0);

    // Locked to an idle master 1: master 0 must wait.
    ifc.lock_i = '0;
    drive_req(0, 7'h05, 2'd1, 32'h0);
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("lock_stall_busy", 64'(busy), 64'(0));
      checkOutput("lock_stall_ready", 64'(ifc.req_ready_o), 64'(0));
    end
    drive_req(1, 7'h23, 2'd1, 32'h0);
    serve_txn(1, 0, 0, 0, 32'h0000_0043, 2'd0);

    m_rr     = 0;
    m_grant  = 1;
    m_locked = 1'b0;

    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < N; m++) begin
        if (!pending[m] && ($urandom_range(0, 1) == 1))
          drive_req(m, 7'($urandom), 2'($urandom_range(1, 2)), $urandom);
      end
      if (m_locked && !pending[m_grant])
        drive_req(m_grant, 7'($urandom), 2'd1, $urandom);
      if (pending == '0) begin
        win = $urandom_range(0, N - 1);
        drive_req(win, 7'($urandom), 2'd1, $urandom);
      end
      for (int m = 0; m < N; m++) lock_bits[m] = ($urandom_range(0, 3) == 0);
      ifc.lock_i = lock_bits;
      win = predict_winner();
      serve_txn(win, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
      m_rr     = (win + 1) % N;
      m_grant  = win;
      m_locked = lock_bits[win];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares the single core-side Debug Module Interface (DMI) of the debug module between several DMI masters, for example the JTAG DTM and an on-chip debug bridge. It sits between the masters' DMI request/response ports and the debug module, on the debug-module clock domain. It arbitrates round-robin, keeps exactly one transaction outstanding, routes each response back to its issuer, and supports an optional per-master lock for multi-access sequences.

## Interface
- NumReq, default 2: number of DMI masters; must be at least 2.
- clk_i  in  1: debug-module clock; all logic is on the rising edge.
- rst_i  in  1: reset, synchronous and active-high.
- req_i  in  NumReq x dm::dmi_req_t: per-master request (addr[6:0], op[1:0], data[31:0]).
- req_valid_i  in  NumReq: per-master request valid.
- req_ready_o  out  NumReq: per-master request accepted.
- lock_i  in  NumReq: master holds its grant after its current transaction completes.
- resp_o  out  NumReq x dm::dmi_resp_t: response data (data[31:0], resp[1:0]), broadcast to all masters.
- resp_valid_o  out  NumReq: per-master response valid.
- resp_ready_i  in  NumReq: per-master response ready.
- dmi_req_o  out  dm::dmi_req_t: request to the debug module.
- dmi_req_valid_o  out  1: request valid to the debug module.
- dmi_req_ready_i  in  1: debug module accepts the request.
- dmi_resp_i  in  dm::dmi_resp_t: response from the debug module.
- dmi_resp_valid_i  in  1: response valid.
- dmi_resp_ready_o  out  1: response accepted.
- busy_o  out  1: high whenever the state is not Idle.
- grant_o  out  $clog2(NumReq): index of the current or last granted master.

## Operation
- The FSM has three states: Idle, Req and Resp.
- **Idle:**
  - Arbitration is round-robin from pointer rr_q, which is reset to 0. The lowest index at or after rr_q, wrapping, with req_valid_i high wins.
  - When locked_q is set, only master grant_q is eligible. The others wait, even if they are valid.
  - The winner index is registered into grant_q. The next state is Req.
  - Idle drives no handshake outputs.
- **Req:**
  - dmi_req_o = req_i[grant_q] and dmi_req_valid_o = req_valid_i[grant_q].
  - req_ready_o[grant_q] = dmi_req_ready_i. All other req_ready_o bits are 0.
  - On the handshake, the next state is Resp.
  - Masters must hold valid and data stable until ready. If a master drops valid, the grant is held anyway and dmi_req_valid_o follows the master.
- **Resp:**
  - resp_valid_o[grant_q] = dmi_resp_valid_i, and dmi_resp_ready_o = resp_ready_i[grant_q].
  - resp_o carries dmi_resp_i to every master; only the granted master's valid is set.
  - On the handshake, the next state is Idle.
  - At the same time, locked_q <= lock_i[grant_q], and rr_q <= grant_q+1 modulo NumReq. The pointer advances even when locked.
- While locked_q = 1, deasserting lock_i has no effect until the next response handshake. A locked master that has no pending request stalls all other masters. This is intentional and supports abstract-command sequences.
- All response and ready outputs not described above are 0.
- Reset, asserted in any state:
  - Next cycle: state = Idle, grant_q = 0, rr_q = 0, locked_q = 0.
  - All valid and ready outputs and busy_o are 0; dmi_req_o = 0.
  - An in-flight transaction is abandoned. The debug module must be reset alongside this block.

## Timing
- Minimum arbitration latency is 1 cycle: req_valid_i rises in Idle at cycle N, and dmi_req_valid_o rises at cycle N+1.
- dmi_req_ready_i, dmi_resp_valid_i and resp_ready_i pass combinationally to the granted master. There are no added pipeline stages.
- With zero-latency ready and response, a transaction takes 3 cycles: Idle, Req, Resp. Back-to-back transactions therefore complete every 3 cycles.
- A master's request valid and response valid are never high in the same cycle.
- Simultaneous requests are resolved in one cycle by rr_q. With all NumReq masters saturated, each master is granted once every NumReq transactions.

## Test plan
- **Single master.** After reset, master 0 requests addr=0x11, op=READ. The DM accepts in 1 cycle and responds data=0x0000_0A5A, resp=SUCCESS 2 cycles later. Required: dmi_req_valid_o high 1 cycle after the request; resp_valid_o = 2'b01 with data 0x0000_0A5A; busy_o low again on the cycle after the response handshake.
- **Round-robin.** Masters 0 and 1 both request continuously with distinct addresses 0x04 and 0x10. Required: grant order 0, 1, 0, 1. dmi_req_o.addr alternates 0x04, 0x10.
- **Lock.** Master 1 holds lock_i = 1 for 3 transactions while master 0 requests throughout. Required: three consecutive grants to master 1, with req_ready_o[0] = 0 the whole time. The grant goes to master 0 only after master 1's handshake with lock_i = 0.
- **Backpressure.** dmi_req_ready_i is held low for 5 cycles, then resp_ready_i[grant] is held low for 4 cycles while dmi_resp_valid_i = 1. Required: dmi_req_o stays stable across all 5 cycles. dmi_resp_ready_o stays 0 and the state remains Resp until resp_ready_i rises.
- **Reset mid-transaction.** Assert rst_i while in Resp. Required: on the next cycle all valid and ready outputs are 0, busy_o = 0 and grant_o = 0. A new request from master 1 is then served normally.
- **Response error passthrough.** The DM returns resp=ERR with data 0xDEAD_BEEF. Required: the granted master receives resp=ERR and data 0xDEAD_BEEF unchanged, and the arbiter returns to Idle.
